// File: rtl/axis_out_compactor_pkg.sv
// -----------------------------------------------------------------------------
// axis_out_compactor_pkg
// Shared types and helpers for the AXI-Stream byte compactor.
//   state_e        : FILL (collecting bytes) / FLUSH (draining the packet tail)
//   keep_to_count  : length of the run of ones in a keep mask starting at bit 0
//   count_to_mask  : prefix mask with the low 'c' bits set
// Helpers operate on MAX_N-bit vectors so one definition serves every
// DATA_WIDTH up to 8*MAX_N; callers zero-extend / truncate with casts.
// -----------------------------------------------------------------------------
package axis_out_compactor_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int MAX_N = 128;

  // Leading-ones count over the low n bits of keep; stops at the first zero.
  function automatic logic [7:0] keep_to_count(input logic [MAX_N-1:0] keep,
                                                input logic [7:0]       n);
    logic [7:0] c;
    logic       run;
    c   = 8'd0;
    run = 1'b1;
    for (int i = 0; i < MAX_N; i++) begin
      if (run && (8'(i) < n) && keep[i]) begin
        c = c + 8'd1;
      end else begin
        run = 1'b0;
      end
    end
    return c;
  endfunction

  // Prefix mask: bit i set for every i below c.
  function automatic logic [MAX_N-1:0] count_to_mask(input logic [7:0] c);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_N; i++) begin
      m[i] = (8'(i) < c);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_compactor_keep_prefix_count.sv
// -----------------------------------------------------------------------------
// keep_prefix_count
// Combinational decode of an input tkeep mask.
//   keep_i      : N-bit byte qualifier
//   k_o         : number of consecutive ones starting at bit 0
//   nonprefix_o : high when any set bit lies above that run
// -----------------------------------------------------------------------------
module keep_prefix_count
  import axis_out_compactor_pkg::*;
#(
  parameter int N  = 16,
  parameter int KW = $clog2(N + 1)
) (
  input  logic [N-1:0]  keep_i,
  output logic [KW-1:0] k_o,
  output logic          nonprefix_o
);

  logic [KW-1:0] k_s;

  // Count the prefix run, then flag any kept bit the prefix mask does not cover.
  always_comb begin
    k_s         = KW'(keep_to_count(MAX_N'(keep_i), 8'(N)));
    nonprefix_o = |(keep_i & ~N'(count_to_mask(8'(k_s))));
  end

  assign k_o = k_s;

endmodule

// File: rtl/axis_out_compactor.sv
// -----------------------------------------------------------------------------
// axis_out_compactor
// Packs the kept bytes of sparse AXI-Stream beats into dense full-width beats;
// only the final beat of a packet may be partial. Reports the packet byte
// total alongside the tlast beat.
//   aclk, areset          : clock, asynchronous active-high reset
//   s_axis_*              : input stream (tkeep expected as a prefix mask)
//   m_axis_*              : compacted output stream
//   m_pkt_bytes           : byte total, valid with the m_axis_tlast beat
//   keep_err              : sticky flag for a non-prefix tkeep on an accepted beat
// Internals: a 2N-byte buffer whose bytes at and above cnt are always zero, so
// new bytes can be OR-merged at offset cnt after the optional output shift.
// All m_axis outputs come straight from flops; nothing on s_axis reaches them
// combinationally.
// -----------------------------------------------------------------------------
module axis_out_compactor
  import axis_out_compactor_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_BITS   = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [CNT_BITS-1:0]     m_pkt_bytes,
  output logic                    keep_err
);

  localparam int N  = DATA_WIDTH / 8;
  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(2 * N);
  localparam int BW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] N_C = CW'(N);

  state_e                state_q, state_d;
  logic [BW-1:0]         buf_q, buf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   pkt_q, pkt_d;
  logic                  err_q, err_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [N-1:0]          tkeep_q, tkeep_d;

  logic [KW-1:0]         k_s;
  logic                  nonprefix_s;
  logic [N-1:0]          kmask_s;
  logic [DATA_WIDTH-1:0] data_m_s;
  logic                  s_ready_s;
  logic                  in_fire_s;
  logic                  out_fire_s;

  keep_prefix_count #(
    .N  (N),
    .KW (KW)
  ) u_keep (
    .keep_i      (s_axis_tkeep),
    .k_o         (k_s),
    .nonprefix_o (nonprefix_s)
  );

  // Input may be taken when the low beat is free or is leaving this cycle.
  assign s_ready_s  = !areset && (state_q == FILL) &&
                      ((cnt_q < N_C) || (tvalid_q && m_axis_tready));
  assign in_fire_s  = s_axis_tvalid && s_ready_s;
  assign out_fire_s = tvalid_q && m_axis_tready;

  // Zero every byte outside the kept prefix so the OR-merge stays clean.
  always_comb begin
    kmask_s  = N'(count_to_mask(8'(k_s)));
    data_m_s = '0;
    for (int i = 0; i < N; i++) begin
      if (kmask_s[i]) begin
        data_m_s[8*i +: 8] = s_axis_tdata[8*i +: 8];
      end else begin
        data_m_s[8*i +: 8] = 8'h00;
      end
    end
  end

  // Next state: output shift/clear first, then append accepted bytes at cnt.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    err_d   = err_q;

    if (out_fire_s) begin
      if (tlast_q) begin
        buf_d   = '0;
        cnt_d   = '0;
        pkt_d   = '0;
        state_d = FILL;
      end else begin
        buf_d = buf_q >> (8 * N);
        cnt_d = cnt_q - N_C;
      end
    end else begin
      buf_d = buf_q;
    end

    if (in_fire_s) begin
      buf_d = buf_d | (BW'(data_m_s) << {cnt_d, 3'b000});
      cnt_d = cnt_d + CW'(k_s);
      pkt_d = pkt_d + CNT_BITS'(k_s);
      err_d = err_q | nonprefix_s;
      if (s_axis_tlast) begin
        state_d = FLUSH;
      end else begin
        state_d = state_d;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Output flags derived from the next buffer state so they can be registered.
  always_comb begin
    tvalid_d = (state_d == FLUSH) || (cnt_d >= N_C);
    tlast_d  = (state_d == FLUSH) && (cnt_d <= N_C);
    if (!tvalid_d) begin
      tkeep_d = '0;
    end else if (tlast_d) begin
      tkeep_d = N'(count_to_mask(8'(cnt_d)));
    end else begin
      tkeep_d = '1;
    end
  end

  // State, buffer, counters and registered output flags.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= FILL;
      buf_q    <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tkeep_q  <= tkeep_d;
    end
  end

  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = buf_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_pkt_bytes   = pkt_q;
  assign keep_err      = err_q;

endmodule

// File: tb/tb_axis_out_compactor.sv
// -----------------------------------------------------------------------------
// tb_axis_out_compactor
// Byte-stream reference model (queue of accepted bytes plus completed packet
// lengths) checked on every output handshake, stall-stability checks, and
// hand-computed literal expectations for the directed scenarios. N = 4.
// -----------------------------------------------------------------------------
module tb_axis_out_compactor;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [N-1:0]  s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [N-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;
  logic [31:0]   m_pkt_bytes;
  logic          keep_err;

  axis_out_compactor #(.DATA_WIDTH(DW), .CNT_BITS(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_pkt_bytes   (m_pkt_bytes),
    .keep_err      (keep_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [31:0] p;
  } beat_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_bytes[$];
  int unsigned pkt_lens[$];
  int unsigned cur_len = 0;
  int          out_cons = 0;
  beat_t       out_log[$];
  bit          bp_en = 1'b0;
  logic        mr_fixed = 1'b0;

  bit          held_v = 1'b0;
  logic [31:0] held_d;
  logic [3:0]  held_k;
  logic        held_l;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < N; i++) m[8*i +: 8] = k[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Output-ready driver: fixed level or toggling every cycle.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (bp_en) m_axis_tready = ~m_axis_tready;
      else       m_axis_tready = mr_fixed;
    end
  end

  // Compare process: check presented beat against the byte model, then absorb
  // this cycle's accepted input into the model.
  always @(negedge aclk) begin
    if (!areset) begin
      if (held_v) begin
        chk("stall_stable",
            {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
            {1'b1, held_l, held_k, held_d});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        int          nb;
        bit          el;
        logic [3:0]  ek;
        logic [31:0] ed;
        beat_t       b;
        if (pkt_lens.size() > 0) begin
          nb = int'(pkt_lens[0]) - out_cons;
          el = (nb <= N);
          if (!el) nb = N;
        end else begin
          nb = N;
          el = 1'b0;
        end
        if (exp_bytes.size() < nb) begin
          chk("beat_underflow", 128'(exp_bytes.size()), 128'(nb));
          nb = exp_bytes.size();
        end
        ek = 4'h0;
        ed = 32'h0;
        for (int i = 0; i < nb; i++) begin
          ek[i] = 1'b1;
          ed[8*i +: 8] = exp_bytes[i];
        end
        chk("out_beat",
            {m_axis_tlast, m_axis_tkeep, m_axis_tdata & byte_mask(ek), el ? m_pkt_bytes : 32'h0},
            {el, ek, ed, el ? pkt_lens[0] : 32'h0});
        for (int i = 0; i < nb; i++) void'(exp_bytes.pop_front());
        out_cons += nb;
        if (el && pkt_lens.size() > 0) begin
          void'(pkt_lens.pop_front());
          out_cons = 0;
        end
        b.d = m_axis_tdata; b.k = m_axis_tkeep; b.l = m_axis_tlast; b.p = m_pkt_bytes;
        out_log.push_back(b);
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata;
      held_k = m_axis_tkeep;
      held_l = m_axis_tlast;
      if (s_axis_tvalid && s_axis_tready) begin
        int k;
        k = 0;
        while (k < N && s_axis_tkeep[k]) begin
          exp_bytes.push_back(s_axis_tdata[8*k +: 8]);
          k++;
        end
        cur_len += k;
        if (s_axis_tlast) begin
          pkt_lens.push_back(cur_len);
          cur_len = 0;
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic sync();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    bit done;
    done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("send_timeout");
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(posedge aclk);
      #2;
      if (exp_bytes.size() == 0 && pkt_lens.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
    else chk("idle_after_drain", 128'(m_axis_tvalid), 128'(0));
    sync();
  endtask

  task automatic lit(input string name, input int idx, input logic [31:0] d,
                     input logic [3:0] k, input logic l, input logic [31:0] p);
    if (idx >= out_log.size()) begin
      chk(name, 128'(out_log.size()), 128'(idx + 1));
    end else begin
      chk(name,
          {out_log[idx].l, out_log[idx].k, out_log[idx].d & byte_mask(k), l ? out_log[idx].p : 32'h0},
          {l, k, d & byte_mask(k), l ? p : 32'h0});
    end
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'h0;
    s_axis_tkeep  = 4'h0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_outputs",
        {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_pkt_bytes, keep_err},
        {1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0});
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", 128'(s_axis_tready), 128'(1));
    mr_fixed = 1'b1;
    sync();
    sync();

    // Dense packet
    out_log.delete();
    send(32'h03020100, 4'hF, 1'b0);
    send(32'h07060504, 4'hF, 1'b1);
    drain();
    chk("dense_count", 128'(out_log.size()), 128'(2));
    lit("dense_b0", 0, 32'h03020100, 4'hF, 1'b0, 32'd0);
    lit("dense_b1", 1, 32'h07060504, 4'hF, 1'b1, 32'd8);

    // Sparse packet
    out_log.delete();
    send(32'h0000A1A0, 4'h3, 1'b0);
    send(32'h0000B1B0, 4'h3, 1'b0);
    send(32'h000000C0, 4'h1, 1'b1);
    drain();
    chk("sparse_count", 128'(out_log.size()), 128'(2));
    lit("sparse_b0", 0, 32'hB1B0A1A0, 4'hF, 1'b0, 32'd0);
    lit("sparse_b1", 1, 32'h000000C0, 4'h1, 1'b1, 32'd5);

    // Empty packet
    out_log.delete();
    send(32'h12345678, 4'h0, 1'b1);
    drain();
    chk("empty_count", 128'(out_log.size()), 128'(1));
    lit("empty_b0", 0, 32'h0, 4'h0, 1'b1, 32'd0);

    // Illegal keep
    chk("keep_err_clear", 128'(keep_err), 128'(0));
    out_log.delete();
    send(32'hDD33BB11, 4'h5, 1'b1);
    drain();
    chk("keep_err_set", 128'(keep_err), 128'(1));
    lit("illegal_b0", 0, 32'h00000011, 4'h1, 1'b1, 32'd1);

    // Backpressure with random prefix keeps
    bp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int k;
      k = $urandom_range(0, 4);
      send($urandom, 4'((1 << k) - 1), (i == 19));
    end
    drain();
    bp_en    = 1'b0;
    mr_fixed = 1'b1;
    sync();
    chk("keep_err_sticky", 128'(keep_err), 128'(1));

    // Mid-packet reset
    mr_fixed = 1'b0;
    sync();
    sync();
    send(32'h000000E0, 4'h1, 1'b0);
    send(32'h000000E1, 4'h1, 1'b0);
    send(32'h000000E2, 4'h1, 1'b0);
    areset = 1'b1;
    exp_bytes.delete();
    pkt_lens.delete();
    cur_len  = 0;
    out_cons = 0;
    @(negedge aclk);
    chk("ready_in_reset", 128'(s_axis_tready), 128'(0));
    @(posedge aclk);
    #1 areset = 1'b0;
    out_log.delete();
    mr_fixed = 1'b1;
    sync();
    sync();
    send(32'h13121110, 4'hF, 1'b0);
    send(32'h17161514, 4'hF, 1'b1);
    drain();
    chk("reset_count", 128'(out_log.size()), 128'(2));
    lit("reset_b0", 0, 32'h13121110, 4'hF, 1'b0, 32'd0);
    lit("reset_b1", 1, 32'h17161514, 4'hF, 1'b1, 32'd8);
    chk("keep_err_after_reset", 128'(keep_err), 128'(0));
    chk("model_empty", 128'(exp_bytes.size() + pkt_lens.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "global timeout");
  end

endmodule
